// File: rtl/dphy_hs_lane_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dphy_hs_lane_ctrl
// Purpose  : Per-lane D-PHY HS entry sequencer and byte aligner. Tracks the
//            LP line state and sequences the deserializer for each burst
//            (reset pulse, enable, settle). It then searches the deserialized
//            stream for the 0xB8 sync byte and delivers byte-aligned payload
//            with SoT/EoT markers.
// Ports    : byte_clk_i, rst_i           - byte clock, async active-high reset
//            lp_data_p_i, lp_data_n_i    - synchronized LP receiver lines
//            byte_data_i[7:0]            - raw deserializer byte (bit 0 first)
//            serdes_rst_o, hs_enable_o   - deserializer control
//            byte_o[7:0], byte_valid_o   - aligned payload
//            sot_o, eot_o, sync_err_o    - single-cycle burst event pulses
// Revision : 1.0 - initial release
// ============================================================================
module dphy_hs_lane_ctrl #(
    parameter int SERDES_RST_CYCLES = 4,
    parameter int SETTLE_CYCLES     = 8,
    parameter int SYNC_TIMEOUT      = 32
) (
    input  logic       byte_clk_i,
    input  logic       rst_i,
    input  logic       lp_data_p_i,
    input  logic       lp_data_n_i,
    input  logic [7:0] byte_data_i,
    output logic       serdes_rst_o,
    output logic       hs_enable_o,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       sot_o,
    output logic       eot_o,
    output logic       sync_err_o
);

    localparam int CNT_MAX_A = (SERDES_RST_CYCLES > SETTLE_CYCLES) ? SERDES_RST_CYCLES : SETTLE_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > SYNC_TIMEOUT) ? CNT_MAX_A : SYNC_TIMEOUT;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        STOP_WAIT = 3'd0,
        IDLE      = 3'd1,
        HS_RQST   = 3'd2,
        RST       = 3'd3,
        SETTLE    = 3'd4,
        SYNC      = 3'd5,
        HS_RX     = 3'd6
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [1:0]       lp;
    logic [7:0]       d0;
    logic [7:0]       d1;
    logic [15:0]      w;
    logic [2:0]       off;
    logic [2:0]       match_off;
    logic             match;
    logic             timeout;
    logic [CNT_W-1:0] cnt;
    logic             rx_first;
    logic             eot_req;
    logic             err_req;

    assign lp = {lp_data_p_i, lp_data_n_i};
    // d1 holds the older byte, so it occupies the low (earlier) bits.
    assign w  = {d0, d1};

    // Scan from the highest offset down so the lowest matching offset is the
    // last assignment and therefore wins.
    always_comb begin
        match     = 1'b0;
        match_off = 3'd0;
        for (int o = 7; o >= 0; o--) begin
            if (w[o +: 8] == 8'hB8) begin
                match     = 1'b1;
                match_off = 3'(o);
            end
        end
    end

    always_comb begin
        next_state = state;
        timeout    = 1'b0;
        case (state)
            STOP_WAIT: if (lp == 2'b11) next_state = IDLE;
            IDLE:      if (lp == 2'b01) next_state = HS_RQST;
            HS_RQST: begin
                if (lp == 2'b00)      next_state = RST;
                else if (lp == 2'b11) next_state = IDLE;
                else if (lp == 2'b10) next_state = STOP_WAIT;
            end
            RST: begin
                if (lp == 2'b11)                                     next_state = IDLE;
                else if (cnt == CNT_W'(SERDES_RST_CYCLES - 1))       next_state = SETTLE;
            end
            SETTLE: begin
                if (lp == 2'b11)                                     next_state = IDLE;
                else if (cnt == CNT_W'(SETTLE_CYCLES - 1))           next_state = SYNC;
            end
            SYNC: begin
                // An LP-11 abort takes priority over both match and timeout.
                if (lp == 2'b11) begin
                    next_state = IDLE;
                end else if (match) begin
                    next_state = HS_RX;
                end else if (cnt == CNT_W'(SYNC_TIMEOUT - 1)) begin
                    next_state = STOP_WAIT;
                    timeout    = 1'b1;
                end
            end
            HS_RX:     if (lp == 2'b11) next_state = IDLE;
            default:   next_state = STOP_WAIT;
        endcase
    end

    always_ff @(posedge byte_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= STOP_WAIT;
        end else begin
            state <= next_state;
        end
    end

    // Outputs are registered from the current state, so each is one cycle
    // behind the state change. The event pulses go through an extra stage so
    // they line up with the valid/enable transitions.
    always_ff @(posedge byte_clk_i or posedge rst_i) begin
        if (rst_i) begin
            d0           <= 8'd0;
            d1           <= 8'd0;
            cnt          <= '0;
            off          <= 3'd0;
            rx_first     <= 1'b0;
            eot_req      <= 1'b0;
            err_req      <= 1'b0;
            serdes_rst_o <= 1'b0;
            hs_enable_o  <= 1'b0;
            byte_o       <= 8'd0;
            byte_valid_o <= 1'b0;
            sot_o        <= 1'b0;
            eot_o        <= 1'b0;
            sync_err_o   <= 1'b0;
        end else begin
            d0 <= byte_data_i;
            d1 <= d0;

            if (next_state != state)        cnt <= '0;
            else if (cnt != CNT_W'(CNT_MAX)) cnt <= cnt + 1'b1;

            if (state == SYNC && next_state == HS_RX) off <= match_off;

            rx_first <= (state == SYNC) && (next_state == HS_RX);
            eot_req  <= (state == HS_RX) && (next_state == IDLE);
            err_req  <= timeout;

            serdes_rst_o <= (state == RST);
            hs_enable_o  <= (state inside {RST, SETTLE, SYNC, HS_RX});
            byte_valid_o <= (state == HS_RX);
            if (state == HS_RX) byte_o <= w[off +: 8];
            sot_o      <= rx_first;
            eot_o      <= eot_req;
            sync_err_o <= err_req;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dphy_hs_lane_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_dphy_hs_lane_ctrl
// Purpose  : Self-checking bench for dphy_hs_lane_ctrl. Each burst is built as
//            a serial bit stream (zero prefix, sync byte at a chosen bit
//            offset, random payload). Expected aligned bytes are sliced
//            straight from that bit stream at the spec-defined latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dphy_hs_lane_ctrl;

    localparam int N = 4;
    localparam int S = 8;
    localparam int T = 32;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       lp_p = 1'b1;
    logic       lp_n = 1'b1;
    logic [7:0] din  = 8'd0;
    logic       serdes_rst_o;
    logic       hs_enable_o;
    logic [7:0] byte_o;
    logic       byte_valid_o;
    logic       sot_o;
    logic       eot_o;
    logic       sync_err_o;

    int checks = 0;
    int errors = 0;

    dphy_hs_lane_ctrl #(
        .SERDES_RST_CYCLES(N),
        .SETTLE_CYCLES    (S),
        .SYNC_TIMEOUT     (T)
    ) dut (
        .byte_clk_i  (clk),
        .rst_i       (rst),
        .lp_data_p_i (lp_p),
        .lp_data_n_i (lp_n),
        .byte_data_i (din),
        .serdes_rst_o(serdes_rst_o),
        .hs_enable_o (hs_enable_o),
        .byte_o      (byte_o),
        .byte_valid_o(byte_valid_o),
        .sot_o       (sot_o),
        .eot_o       (eot_o),
        .sync_err_o  (sync_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge; outputs are then stable for that edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lp(input logic [1:0] v);
        lp_p = v[1];
        lp_n = v[0];
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_serdes_rst"}, 32'(serdes_rst_o), 32'd0);
        check({tag, "_hs_en"},      32'(hs_enable_o),  32'd0);
        check({tag, "_valid"},      32'(byte_valid_o), 32'd0);
    endtask

    // One full burst: sync byte starts at bit 8*kk+o of the stream, where
    // stream byte i is sampled at edge k+i (k = edge that samples LP-00).
    task automatic run_burst(input int o, input int kk, input int plen, input bit fixed);
        logic [1023:0] bs;
        logic [7:0]    pb;
        int            fv;
        int            len;
        bs = '0;
        bs[8*kk+o +: 8] = 8'hB8;
        for (int j = 0; j < plen + 6; j++) begin
            pb = 8'($urandom);
            if (fixed && j == 0) pb = 8'h12;
            if (fixed && j == 1) pb = 8'h34;
            bs[8*kk+o+8+8*j +: 8] = pb;
        end
        fv  = kk + 3;          // first valid output edge offset from k
        len = fv + plen;       // LP-11 sampled at edge k+len
        set_lp(2'b01); din = 8'd0; step();
        set_lp(2'b00); din = bs[7:0]; step();
        check("rst_at_k", 32'(serdes_rst_o), 32'd0);
        for (int i = 1; i <= len; i++) begin
            set_lp((i == len) ? 2'b11 : 2'b00);
            din = bs[8*i +: 8];
            step();
            check("serdes_rst", 32'(serdes_rst_o), 32'(i <= N));
            check("hs_en",      32'(hs_enable_o),  32'd1);
            check("valid",      32'(byte_valid_o), 32'(i >= fv));
            check("sot",        32'(sot_o),        32'(i == fv));
            check("eot_early",  32'(eot_o),        32'd0);
            check("err_early",  32'(sync_err_o),   32'd0);
            if (i >= fv) check("byte", 32'(byte_o), 32'(bs[8*(i-2)+o +: 8]));
        end
        check("off", 32'(dut.off), 32'(o));
        din = 8'($urandom);
        step();
        check("eot_pulse",  32'(eot_o),        32'd1);
        check("eot_valid",  32'(byte_valid_o), 32'd0);
        check("eot_hs_en",  32'(hs_enable_o),  32'd0);
        check("eot_state",  32'(dut.state),    32'd1);
        step();
        check("eot_once",   32'(eot_o),        32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bit reached;

        // Reset state
        step(); step();
        check("rst_serdes", 32'(serdes_rst_o), 32'd0);
        check("rst_hs_en",  32'(hs_enable_o),  32'd0);
        check("rst_byte",   32'(byte_o),       32'd0);
        check("rst_valid",  32'(byte_valid_o), 32'd0);
        check("rst_sot",    32'(sot_o),        32'd0);
        check("rst_eot",    32'(eot_o),        32'd0);
        check("rst_err",    32'(sync_err_o),   32'd0);
        check("rst_off",    32'(dut.off),      32'd0);
        rst = 1'b0;
        set_lp(2'b11);
        step(); step();

        // Directed: offset 0 after full settle, offset 3, window boundaries
        run_burst(0, N + S, 2, 1'b1);
        run_burst(3, N + S, 3, 1'b1);
        run_burst(5, N + S - 1, 4, 1'b0);
        run_burst(7, N + S + T - 2, 3, 1'b0);

        // Randomized bursts
        for (int b = 0; b < 10; b++)
            run_burst(int'($urandom_range(0, 7)), N + S - 1 + int'($urandom_range(0, 12)),
                      int'($urandom_range(1, 20)), 1'b0);

        // Sync timeout
        set_lp(2'b01); din = 8'd0; step();
        set_lp(2'b00); step();
        for (int i = 1; i <= N + S + T + 1; i++) begin
            din = 8'd0;
            step();
            check("to_hs_en", 32'(hs_enable_o), 32'(i <= N + S + T));
            check("to_err",   32'(sync_err_o),  32'(i == N + S + T + 1));
            check("to_valid", 32'(byte_valid_o), 32'd0);
        end
        step();
        check("to_err_once", 32'(sync_err_o), 32'd0);
        for (int i = 0; i < 10; i++) begin
            set_lp((i % 2 == 0) ? 2'b01 : 2'b00);
            din = 8'hB8;
            step();
            check_quiet("to_locked");
        end
        set_lp(2'b11); din = 8'd0; step();
        run_burst(int'($urandom_range(0, 7)), N + S + 2, 5, 1'b0);

        // Aborted request 11->01->11
        set_lp(2'b01); step();
        set_lp(2'b11); step();
        for (int i = 0; i < 4; i++) begin
            step();
            check_quiet("abort11");
        end
        run_burst(2, N + S, 3, 1'b0);

        // Aborted request 01->10 lands in STOP_WAIT
        set_lp(2'b01); step();
        set_lp(2'b10); step();
        set_lp(2'b01); step();
        set_lp(2'b00);
        for (int i = 0; i < 6; i++) begin
            step();
            check_quiet("abort10");
        end
        set_lp(2'b11); step();
        run_burst(4, N + S + 1, 4, 1'b0);

        // Async reset in HS_RX
        reached = 1'b0;
        set_lp(2'b01); din = 8'd0; step();
        set_lp(2'b00); step();
        for (int i = 1; i <= 60 && !reached; i++) begin
            din = (i == N + S) ? 8'hB8 : ((i > N + S) ? 8'($urandom) : 8'd0);
            step();
            if (byte_valid_o) reached = 1'b1;
        end
        check("ar_reach_rx", 32'(reached), 32'd1);
        step(); step();
        #2 rst = 1'b1;
        #1;
        check("ar_serdes", 32'(serdes_rst_o), 32'd0);
        check("ar_hs_en",  32'(hs_enable_o),  32'd0);
        check("ar_byte",   32'(byte_o),       32'd0);
        check("ar_valid",  32'(byte_valid_o), 32'd0);
        check("ar_sot",    32'(sot_o),        32'd0);
        check("ar_eot",    32'(eot_o),        32'd0);
        check("ar_err",    32'(sync_err_o),   32'd0);
        step();
        rst = 1'b0;
        set_lp(2'b00);
        for (int i = 0; i < 5; i++) begin
            step();
            check_quiet("ar_lp00");
        end
        set_lp(2'b01); step();
        set_lp(2'b00);
        for (int i = 0; i < 5; i++) begin
            step();
            check_quiet("ar_no_req");
        end
        set_lp(2'b11); step();
        run_burst(int'($urandom_range(0, 7)), N + S + 3, 6, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dphy_hs_lane_ctrl.md
# dphy_hs_lane_ctrl

Per-lane high-speed entry sequencer and byte aligner for the CSI-2 D-PHY receive path. It watches the lane's low-power (LP) line state, sequences the HS deserializer for each burst (reset pulse, enable, settle) and searches the deserialized stream for the 0xB8 sync byte. After sync it delivers byte-aligned payload with start/end-of-transmission markers to the lane merger. One instance sits beside each HS data receiver, in the byte clock domain.

## Interface
- SERDES_RST_CYCLES, 4: byte clocks the deserializer reset is held; must be ≥ 2, because the receiver double-registers its reset.
- SETTLE_CYCLES, 8: byte clocks ignored after the reset pulse (T_HS-SETTLE), 1..255.
- SYNC_TIMEOUT, 32: byte clocks allowed to find sync before error, 1..255.
- byte_clk_i  in  1  byte clock; all logic on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- lp_data_p_i  in  1  LP receiver, P line, already synchronized to byte_clk_i.
- lp_data_n_i  in  1  LP receiver, N line, already synchronized to byte_clk_i.
- byte_data_i  in  8  raw deserializer byte; bit 0 is the earliest received bit.
- serdes_rst_o  out  1  deserializer reset request.
- hs_enable_o  out  1  deserializer clock enable.
- byte_o  out  8  aligned payload byte.
- byte_valid_o  out  1  byte_o qualifier.
- sot_o  out  1  one-cycle pulse with the first payload byte.
- eot_o  out  1  one-cycle pulse when the burst ends.
- sync_err_o  out  1  one-cycle pulse on sync timeout.

## Operation
- LP state is the 2-bit value {lp_data_p_i, lp_data_n_i}: 11 = LP-11 (stop), 01 = LP-01 (HS request), 00 = LP-00 (bridge).
- FSM states and transitions:
  - STOP_WAIT: go to IDLE on LP-11. This is the reset state.
  - IDLE: go to HS_RQST on LP-01.
  - HS_RQST: go to RST on LP-00; return to IDLE on LP-11; go to STOP_WAIT on LP-10.
  - RST: serdes_rst_o=1 and hs_enable_o=1 for SERDES_RST_CYCLES cycles, then go to SETTLE.
  - SETTLE: hs_enable_o=1 for SETTLE_CYCLES cycles, then go to SYNC.
  - SYNC: search for the sync byte. On match go to HS_RX. After SYNC_TIMEOUT cycles without a match, pulse sync_err_o and go to STOP_WAIT.
  - HS_RX: stream payload. On LP-11, pulse eot_o and go to IDLE.
- LP-11 seen in RST, SETTLE or SYNC aborts the burst: go to IDLE, no eot_o, no sync_err_o.
- hs_enable_o is low in STOP_WAIT, IDLE and HS_RQST.
- Pipeline registers: d0 <= byte_data_i; d1 <= d0 (always running). The search window w = {d0, d1} is 16 bits, with d1 holding the older bits.
- Sync search: in SYNC, compare w[o+7:o] against 8'hB8 for o = 0..7.
  - If several offsets match, the lowest o wins.
  - The winning offset is latched into a 3-bit register `off` and held until the next SYNC entry.
- HS_RX output: each cycle byte_o <= w[off+7:off] and byte_valid_o <= 1. The sync byte itself is never output.
- sot_o is asserted together with the first byte_valid_o of each burst.
- byte_valid_o drops in the same cycle that eot_o pulses. Garbage trailer bytes (EoT) are passed through; the packet layer strips them.
- Counters are sized $clog2(max+1), reload on state entry, and saturate.

## Timing
- Reset values: serdes_rst_o=0, hs_enable_o=0, byte_o=0, byte_valid_o=0, sot_o=0, eot_o=0, sync_err_o=0, off=0, d0=d1=0, state=STOP_WAIT.
- All outputs are registered.
- LP-00 sampled at edge k (state HS_RQST): serdes_rst_o and hs_enable_o are high from edge k+1.
- serdes_rst_o falls at edge k+1+SERDES_RST_CYCLES.
- SYNC is entered SERDES_RST_CYCLES+SETTLE_CYCLES cycles after RST entry.
- Alignment latency: byte_data_i sampled at edge j appears in w at edge j+1. The registered byte_o derived from w appears at edge j+2.
- Example: with off=0, the byte sampled at edge j is output at edge j+2.
- Match found on the window valid after edge t: first byte_valid_o/sot_o at edge t+2. It carries the payload byte that follows sync.
- LP-11 sampled at edge m in HS_RX: eot_o=1 and byte_valid_o=0 from edge m+1.
- Async reset mid-burst: all outputs clear immediately. The FSM then needs LP-11 before any new request is accepted.

## Test plan
- Full entry at offset 0, defaults:
  - Stimulus: LP sequence 11→01→00. serdes_rst_o high exactly 4 cycles, then 8 settle cycles, with byte_data_i=0x00.
  - Then drive 0xB8, 0x12, 0x34.
  - Required: sot_o with byte_o=0x12, then byte_o=0x34.
- Offset 3 sync:
  - Stimulus: after settle, byte_data_i = 0x00, 0xC0, 0x95, 0xA0.
  - Required: off=3; the first valid byte_o=0x12 with sot_o.
- Sync timeout:
  - Stimulus: after settle, 0x00 for 32 cycles.
  - Required: sync_err_o pulse, hs_enable_o=0. No valid output until LP-11 followed by a new request.
- End of burst:
  - Stimulus: LP-11 during HS_RX.
  - Required: one eot_o pulse, byte_valid_o=0 on the same edge, state IDLE, hs_enable_o=0.
- Aborted request:
  - Stimulus: LP 11→01→11 → return to IDLE with serdes_rst_o never asserted.
  - Stimulus: LP 01→10 → STOP_WAIT.
- Async reset:
  - Stimulus: rst_i asserted mid-HS_RX.
  - Required: all outputs 0 immediately. After release, LP-00 alone does not start a burst.
